uart_fsm_tx: RTL and testbench

UART transmitter FSM that serializes one 8-bit byte per request onto a single `tx` line. Frame format is 8N1 by default, sent LSB first with a fixed integer clock-per-bit divider. It is the transmit-side counterpart of the `FSMRX` receiver and shares its baud convention (20 clocks per bit by default). A `tx`→`rx` loopback must therefore round-trip bytes unchanged.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_fsm_tx.sv | 136 +++++++++++++
 tb/tb_uart_fsm_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver.
// Contents: the frame state encoding, the data width, the default baud divider,
// and an even-parity helper. The helper is used only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 20;
  localparam int unsigned UART_IDX_W        = $clog2(UART_DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud strobe generator. It counts 0..CLKS_PER_BIT-1 while enabled and pulses
// tick on the last clock of each bit period. The receiver uses the same block.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear of the counter; takes priority over en
//   en       : count enable; tick is forced low while en is low
//   tick     : high on the last clock of each bit period
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Wrapping bit-period counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_fsm_tx.sv
// UART transmitter. It sends one byte per accepted start request, LSB first.
// The default frame is 8N1. Defining UART_TX_PARITY_EN inserts an even-parity
// bit after D7.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   start    : transmit request; accepted only while idle
//   datain   : byte to send; latched on the accepting edge
//   tx       : serial line (registered); idles high
//   busy     : high from the accepting edge until the frame completes (registered)
//   Done     : one-cycle pulse on the frame-completion edge (registered)
//   tick     : baud strobe; high on the last clock of each bit period
module uart_fsm_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [UART_DATA_BITS-1:0] datain,
  output logic                      tx,
  output logic                      busy,
  output logic                      Done,
  output logic                      tick
);

  localparam logic [UART_IDX_W-1:0] LAST_IDX  = UART_IDX_W'(UART_DATA_BITS - 1);
  localparam logic                  LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e               state;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_IDX_W-1:0]     idx;
  logic                      stop_cnt;
  logic                      baud_clr;
  logic                      baud_en;
`ifdef UART_TX_PARITY_EN
  logic                      par;
`endif

  // The counter is held at zero while idle, so bit timing starts at the accepting edge.
  assign baud_clr = (state == ST_IDLE);
  assign baud_en  = (state != ST_IDLE);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .en   (baud_en),
    .tick (tick)
  );

  // Frame FSM. tx is loaded one bit period ahead, so the line is a register output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shift    <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      Done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_START;
            shift <= datain;
            tx    <= 1'b0;
            busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par   <= even_parity(datain);
`endif
          end
        end
        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            idx   <= '0;
            tx    <= shift[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state    <= ST_PARITY;
              tx       <= par;
`else
              state    <= ST_STOP;
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
`endif
            end else begin
              // After the shift, shift[0] is the bit currently on the line.
              shift <= {1'b0, shift[UART_DATA_BITS-1:1]};
              tx    <= shift[1];
              idx   <= idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state    <= ST_STOP;
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (stop_cnt == LAST_STOP) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              Done  <= 1'b1;
              tx    <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fsm_tx.sv
// Directed testbench for uart_fsm_tx with the default parameters (N=20, one stop bit).
// The bench samples the line at the middle of each bit to decode bytes.
// When UART_TX_PARITY_EN is defined, the bench also checks the parity frame.
module tb_uart_fsm_tx;

  localparam int N = 20;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int TLEN = 600;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] datain = 8'h00;
  logic       tx, busy, Done, tick;

  int vectors = 0;
  int errors  = 0;

  logic tr_tx   [0:TLEN-1];
  logic tr_busy [0:TLEN-1];
  logic tr_done [0:TLEN-1];
  logic tr_tick [0:TLEN-1];

  logic [9:0] pat;
  int         glitches;
  logic [7:0] lb [0:3];

  uart_fsm_tx dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .datain (datain),
    .tx     (tx),
    .busy   (busy),
    .Done   (Done),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request at a negedge and return at the negedge after the accepting edge (m=0).
  task automatic accept(input logic [7:0] b, input bit hold);
    start  = 1'b1;
    datain = b;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Record outputs for len cycles (index m = cycles after the accepting edge).
  // At m==pulse_at, raise start with datain=FF. At m==drop_at, drop start.
  task automatic watch(input int len, input int pulse_at, input int drop_at);
    for (int m = 0; m < len; m++) begin
      if (m == pulse_at) begin start = 1'b1; datain = 8'hFF; end
      if (m == drop_at)  start = 1'b0;
      tr_tx[m]   = tx;
      tr_busy[m] = busy;
      tr_done[m] = Done;
      tr_tick[m] = tick;
      @(negedge clk);
    end
  endtask

  function automatic logic [7:0] decode(input int base);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = tr_tx[base + (1 + i) * N + N / 2];
    return d;
  endfunction

  function automatic int count_done(input int len);
    int c = 0;
    for (int m = 0; m < len; m++) if (tr_done[m] === 1'b1) c++;
    return c;
  endfunction

  function automatic int first_done(input int len);
    for (int m = 0; m < len; m++) if (tr_done[m] === 1'b1) return m;
    return -1;
  endfunction

  function automatic int count_busy(input int len);
    int c = 0;
    for (int m = 0; m < len; m++) if (tr_busy[m] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_tick(input int len);
    int c = 0;
    for (int m = 0; m < len; m++) if (tr_tick[m] === 1'b1) c++;
    return c;
  endfunction

  initial begin
    // Reset state.
    @(posedge clk);
    @(negedge clk);
    chk("rst_tx",   32'(tx),   32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame of 8'b10010101.
    accept(8'h95, 1'b0);
    watch(FB * N + 20, -1, -1);
    for (int i = 0; i < 9; i++) pat[i] = tr_tx[i * N + N / 2];
    pat[9] = tr_tx[(FB - 1) * N + N / 2];
    chk("f1_line",     32'(pat), 32'(10'b1100101010));
    chk("f1_byte",     32'(decode(0)), 32'h95);
    chk("f1_done_at",  32'(first_done(FB * N + 20)), 32'(FB * N));
    chk("f1_done_cnt", 32'(count_done(FB * N + 20)), 32'd1);
    chk("f1_busy_cnt", 32'(count_busy(FB * N + 20)), 32'(FB * N));
    glitches = 0;
    for (int m = 1; m < FB * N; m++)
      if ((tr_tx[m] !== tr_tx[m - 1]) && ((m % N) != 0)) glitches++;
    chk("f1_glitches", 32'(glitches), 32'd0);
    chk("f1_tick_lo",  32'(tr_tick[N - 2]), 32'd0);
    chk("f1_tick_hi",  32'(tr_tick[N - 1]), 32'd1);
    chk("f1_tick_cnt", 32'(count_tick(FB * N + 20)), 32'(FB));

    // Back-to-back: start held high. datain changes to C3 after the first accept.
    accept(8'h3C, 1'b1);
    datain = 8'hC3;
    watch(2 * FB * N + 30, -1, FB * N + 1);
    chk("b2b_byte0",   32'(decode(0)), 32'h3C);
    chk("b2b_gap",     32'(tr_tx[FB * N]), 32'd1);
    chk("b2b_start1",  32'(tr_tx[FB * N + 1]), 32'd0);
    chk("b2b_byte1",   32'(decode(FB * N + 1)), 32'hC3);
    chk("b2b_done_cnt", 32'(count_done(2 * FB * N + 30)), 32'd2);
    chk("b2b_busy_cnt", 32'(count_busy(2 * FB * N + 30)), 32'(2 * FB * N));

    // Busy-ignore: a start pulse with FF in the middle of an 0x00 frame.
    accept(8'h00, 1'b0);
    watch(FB * N + 40, 3 * N + 7, 3 * N + 8);
    chk("ign_byte",     32'(decode(0)), 32'h00);
    chk("ign_done_cnt", 32'(count_done(FB * N + 40)), 32'd1);
    chk("ign_busy_cnt", 32'(count_busy(FB * N + 40)), 32'(FB * N));
    chk("ign_idle_tx",  32'(tr_tx[FB * N + 20]), 32'd1);

    // Reset during D3 of 0x55. D3 is 0, so a rise of tx to 1 is visible.
    accept(8'h55, 1'b0);
    repeat (4 * N + 5) @(negedge clk);
    chk("rst_d3_tx", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstm_tx",   32'(tx),   32'd1);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_done", 32'(Done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rstm_done2", 32'(Done), 32'd0);
    rst = 1'b0;
    accept(8'hAA, 1'b0);
    watch(FB * N + 10, -1, -1);
    chk("rstm_byte",    32'(decode(0)), 32'hAA);
    chk("rstm_done_at", 32'(first_done(FB * N + 10)), 32'(FB * N));
    chk("rstm_done_cnt", 32'(count_done(FB * N + 10)), 32'd1);

    // Loopback decode of the representative bytes.
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'hA5; lb[3] = 8'h95;
    for (int k = 0; k < 4; k++) begin
      accept(lb[k], 1'b0);
      watch(FB * N + 5, -1, -1);
      chk($sformatf("lb_byte_%0d", k),    32'(decode(0)), 32'(lb[k]));
      chk($sformatf("lb_done_at_%0d", k), 32'(first_done(FB * N + 5)), 32'(FB * N));
    end

`ifdef UART_TX_PARITY_EN
    // Parity frame for 0x07 (three ones, so the parity bit is 1).
    accept(8'h07, 1'b0);
    watch(FB * N + 10, -1, -1);
    chk("par_byte",    32'(decode(0)), 32'h07);
    chk("par_bit",     32'(tr_tx[9 * N + N / 2]), 32'd1);
    chk("par_stop",    32'(tr_tx[10 * N + N / 2]), 32'd1);
    chk("par_done_at", 32'(first_done(FB * N + 10)), 32'(11 * N));
    chk("par_busy",    32'(tr_busy[11 * N - 1]), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
